instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Supplies the 18-bit instruction stream consumed by the ControlUnit decoder. Holds the PC,
//  fetches from instruction memory, presents one instruction with valid/ready, and applies
//  decoder redirects (isJump/JumpAddress).
//  Keeps a one-entry prefetch of PC+1 so straight-line code issues one instruction per cycle.
// PARAMETERS
//  INSTR_W    18   instruction width; opcode = Instruction[17:14]
//  ADDR_W     14   PC / JumpAddress width
//  RESET_PC   0    PC loaded on reset
//  HALT_OP    4'hF opcode that stops fetch once accepted
// PORTS
//  Clock        in   1        rising-edge clock
//  Reset        in   1        synchronous, active-high
//  imem_req     out  1        fetch request; held with stable imem_addr until imem_valid
//  imem_addr    out  ADDR_W   fetch address
//  imem_valid   in   1        response strobe; counts only while imem_req=1
//  imem_rdata   in   INSTR_W  instruction word, valid with imem_valid
//  Instruction  out  INSTR_W  instruction presented to decoder
//  instr_valid  out  1        Instruction/pc valid
//  instr_ready  in   1        decoder accepts; transfer = instr_valid & instr_ready
//  isJump       in   1        redirect; sampled only on transfer
//  JumpAddress  in   ADDR_W   redirect target; sampled only on transfer
//  pc           out  ADDR_W   address of presented instruction
//  halted       out  1        fetch stopped by HALT_OP
// BEHAVIOUR
//  Reset: imem_req=0, imem_addr=RESET_PC, Instruction=0, instr_valid=0, pc=RESET_PC, halted=0,
//   prefetch empty, state FETCH. Reset mid-request abandons it; later imem_valid is ignored.
//  Memory protocol: at most one outstanding request. Response is taken in the cycle
//   imem_req&imem_valid; zero-wait-state responses are allowed. imem_req may drop only after that.
//  Registered outputs: a response reaches Instruction/instr_valid one cycle after imem_valid.
//  States:
//   FETCH: request at fetch_pc. On response, load output reg, pc=fetch_pc, fetch_pc+1 -> PRESENT.
//   PRESENT: instr_valid=1; Instruction/pc stable until transfer. If prefetch empty and no request
//    is outstanding, request fetch_pc (speculative PC+1).
//    Transfer, isJump=0: if prefetch full (or response arrives this cycle), move it to output
//     and stay in PRESENT (back-to-back). Else instr_valid=0 and continue in FETCH;
//     any outstanding request completes there.
//    Transfer, isJump=1: clear prefetch; fetch_pc=JumpAddress. If a request is outstanding,
//     go to DRAIN, else FETCH.
//    Transfer of opcode==HALT_OP (jump ignored): go to HALT.
//   DRAIN: imem_req held at old address until imem_valid; discard data -> FETCH at target.
//   HALT: instr_valid=0, halted=1, no new requests. An outstanding request completes; data
//    discarded. Only Reset leaves HALT.
//  Arithmetic: fetch_pc increments modulo 2^ADDR_W (0x3FFF+1 -> 0x0000).
//  Simultaneous: a response in the transfer cycle with isJump=1 is discarded. Without jump it is
//   forwarded straight to the output reg.
// CONFIGURATION
//  IFETCH_PERF_EN defined: adds outputs retired_cnt[31:0] (+1 per transfer) and
//   redirect_cnt[15:0] (+1 per transfer with isJump=1). Both clear on Reset and wrap.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package cpu_pkg: INSTR_W, ADDR_W, opcode enum (ADD..JBE, HALT=4'hF),
//   fetch state enum {FETCH, PRESENT, DRAIN, HALT}.
//  Sub-module: ifetch_prefetch_buf, one-entry {valid, instr, addr} register with load/clear/pop.
//  All other logic stays inline.
// TESTING
//  1 Reset, zero-wait memory, instr_ready=1, mem[0..3]=ADD words: transfers at pc 0,1,2,3
//    on consecutive cycles once the first instruction is presented.
//  2 Transfer of JMP at pc=5 with isJump=1, JumpAddress=0x0100, prefetch of 6 in flight with
//    3-cycle latency: request for 6 completes and is dropped. Next presented pc=0x0100.
//    No instruction from 6 is presented.
//  3 instr_ready=0 for 10 cycles at pc=2: Instruction/pc stable, one prefetch of 3 issued,
//    imem_req=0 afterwards.
//  4 fetch_pc=0x3FFF, sequential transfer: next request addr=0x0000.
//  5 Transfer of 18'h3C000 (HALT_OP): halted=1 next cycle, instr_valid=0, no further imem_req.
//    Reset restarts at RESET_PC.
//  6 Reset asserted during a WAIT request: imem_valid the following cycle is ignored.
//    The first presented instruction comes from RESET_PC. With IFETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/address widths, opcode encoding and fetch FSM states.
package cpu_pkg;

    localparam int INSTR_W = 18;
    localparam int ADDR_W  = 14;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_LDI  = 4'h8,
        OP_MOV  = 4'h9,
        OP_CMP  = 4'hA,
        OP_JMP  = 4'hB,
        OP_JE   = 4'hC,
        OP_JBE  = 4'hD,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        PRESENT = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/ifetch_prefetch_buf.sv
// One-entry prefetch register holding {valid, instr, addr}; clear wins over load, load over pop.
module ifetch_prefetch_buf
    import cpu_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load,
    input  logic               clear,
    input  logic               pop,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_addr,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  addr
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            addr_d  = load_addr;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign addr  = addr_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding imem fetch, PC+1 prefetch, decoder redirects.
// Define IFETCH_PERF_EN to add the retired_cnt / redirect_cnt performance counters.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] Instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               isJump,
    input  logic [ADDR_W-1:0]  JumpAddress,
    output logic [ADDR_W-1:0]  pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0]        retired_cnt,
    output logic [15:0]        redirect_cnt,
`endif
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic               pend_q, pend_d;
    logic               fetch_en_q, fetch_en_d;

    logic               req_raw, resp, xfer, outstanding;
    logic               pf_load, pf_clear, pf_pop, pf_valid;
    logic [INSTR_W-1:0] pf_instr;
    logic [ADDR_W-1:0]  pf_addr;

    ifetch_prefetch_buf u_prefetch (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (pf_load),
        .clear      (pf_clear),
        .pop        (pf_pop),
        .load_instr (imem_rdata),
        .load_addr  (fetch_pc_q),
        .valid      (pf_valid),
        .instr      (pf_instr),
        .addr       (pf_addr)
    );

    // DRAIN and HALT keep an abandoned request alive at its original address until it completes.
    always_comb begin
        req_raw   = 1'b0;
        imem_addr = fetch_pc_q;
        unique case (state_q)
            FETCH:   req_raw = 1'b1;
            PRESENT: req_raw = !pf_valid;
            DRAIN, HALT: begin
                req_raw   = pend_q;
                imem_addr = pend_addr_q;
            end
            default: req_raw = 1'b0;
        endcase
    end

    // fetch_en_q holds off requests for the cycle after reset so a stale response is never taken.
    assign imem_req    = fetch_en_q & req_raw;
    assign resp        = imem_req & imem_valid;
    assign outstanding = imem_req & ~imem_valid;
    assign xfer        = valid_q & instr_ready;
    assign fetch_en_d  = 1'b1;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pf_load     = 1'b0;
        pf_clear    = 1'b0;
        pf_pop      = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (resp) begin
                    instr_d    = imem_rdata;
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    valid_d    = 1'b1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (xfer && opcode_of(instr_q) == HALT_OP) begin
                    valid_d     = 1'b0;
                    halted_d    = 1'b1;
                    pf_clear    = 1'b1;
                    pend_d      = outstanding;
                    pend_addr_d = fetch_pc_q;
                    state_d     = HALT;
                end else if (xfer && isJump) begin
                    valid_d     = 1'b0;
                    pf_clear    = 1'b1;
                    fetch_pc_d  = JumpAddress;
                    pend_d      = outstanding;
                    pend_addr_d = fetch_pc_q;
                    state_d     = outstanding ? DRAIN : FETCH;
                end else if (xfer && pf_valid) begin
                    instr_d = pf_instr;
                    pc_d    = pf_addr;
                    pf_pop  = 1'b1;
                end else if (xfer && resp) begin
                    instr_d    = imem_rdata;
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                end else if (xfer) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (resp) begin
                    pf_load    = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (resp) begin
                    pend_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (resp) pend_d = 1'b0;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            pc_q        <= RESET_PC;
            pend_addr_q <= RESET_PC;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            pend_q      <= 1'b0;
            fetch_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            pend_q      <= pend_d;
            fetch_en_q  <= fetch_en_d;
        end
    end

    assign Instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        retired_cnt_d  = retired_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (xfer) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
            if (isJump) redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            retired_cnt_q  <= '0;
            redirect_cnt_q <= '0;
        end else begin
            retired_cnt_q  <= retired_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign retired_cnt  = retired_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a memory model with per-address latency, a decoder
// model that jumps on JMP, and a scoreboard of expected {pc, instruction} transfers.
module tb_instruction_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] Instruction;
    logic               instr_valid;
    logic               instr_ready;
    logic               isJump;
    logic [ADDR_W-1:0]  JumpAddress;
    logic [ADDR_W-1:0]  pc;
    logic               halted;
`ifdef IFETCH_PERF_EN
    logic [31:0]        retired_cnt;
    logic [15:0]        redirect_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];
    int unsigned        wait_cnt;
    int unsigned        lat_base;
    int unsigned        lat_eff;
    logic               force_valid;
    logic [INSTR_W-1:0] force_data;

    exp_t               exp_q[$];
    exp_t               exp_e;
    logic [ADDR_W-1:0]  hs_log[$];
    int                 xfer_cyc_log[$];

    instruction_fetch_unit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .isJump      (isJump),
        .JumpAddress (JumpAddress),
        .pc          (pc),
`ifdef IFETCH_PERF_EN
        .retired_cnt (retired_cnt),
        .redirect_cnt(redirect_cnt),
`endif
        .halted      (halted)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Memory: address 6 always answers after 3 wait cycles, everything else after lat_base.
    always_comb begin
        lat_eff = lat_base;
        if (imem_addr == 14'h0006) lat_eff = 3;
    end

    assign imem_valid = force_valid | (imem_req & (wait_cnt >= lat_eff));
    assign imem_rdata = force_valid ? force_data : mem[imem_addr];

    always @(posedge Clock) begin
        if (Reset || !imem_req || imem_valid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    assign isJump      = (Instruction[INSTR_W-1 -: 4] == 4'hB);
    assign JumpAddress = Instruction[ADDR_W-1:0];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy);
        Reset       = rst;
        instr_ready = rdy;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] p, input logic [INSTR_W-1:0] w);
        exp_t e;
        e.pc    = p;
        e.instr = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_halted(input int budget, output int seen_cyc);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        seen_cyc = cyc;
        checkOutput("halt_reached", 32'(halted), 1);
    endtask

    // Scoreboard: every transfer must match the oldest expected entry.
    always @(negedge Clock) begin
        if (!Reset && imem_req && imem_valid) hs_log.push_back(imem_addr);
        if (!Reset && instr_valid && instr_ready) begin
            xfer_cyc_log.push_back(cyc);
            checkOutput("sb_expected_xfer", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                checkOutput("sb_pc", 32'(pc), 32'(exp_e.pc));
                checkOutput("sb_instr", 32'(Instruction), 32'(exp_e.instr));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hc;
        int req_seen;
        int hs_before;
        int idx;
        int n;
        int cnt6;

        applyStimulus(1'b1, 1'b1);
        force_valid = 1'b0;
        force_data  = '0;
        lat_base    = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {4'h1, 14'(i)};

        // Run 1: straight-line zero-wait code, redirect over a slow prefetch, then HALT.
        mem[0]      = 18'h00011;
        mem[1]      = 18'h00022;
        mem[2]      = 18'h00033;
        mem[3]      = 18'h00044;
        mem[4]      = 18'h00055;
        mem[5]      = 18'h2C100;
        mem[6]      = 18'h02AAA;
        mem[14'h100] = 18'h00066;
        mem[14'h101] = 18'h3C000;
        push_exp(14'h0000, 18'h00011);
        push_exp(14'h0001, 18'h00022);
        push_exp(14'h0002, 18'h00033);
        push_exp(14'h0003, 18'h00044);
        push_exp(14'h0004, 18'h00055);
        push_exp(14'h0005, 18'h2C100);
        push_exp(14'h0100, 18'h00066);
        push_exp(14'h0101, 18'h3C000);

        tick();
        tick();
        checkOutput("rst_imem_req", 32'(imem_req), 0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 0);
        checkOutput("rst_instruction", 32'(Instruction), 0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 0);
        checkOutput("rst_pc", 32'(pc), 0);
        checkOutput("rst_halted", 32'(halted), 0);
        applyStimulus(1'b0, 1'b1);

        wait_halted(200, hc);
        checkOutput("run1_all_retired", 32'(exp_q.size()), 0);
        checkOutput("run1_xfer_count", 32'(xfer_cyc_log.size()), 8);
        if (xfer_cyc_log.size() >= 4) begin
            for (int i = 0; i < 3; i++)
                checkOutput("b2b_gap", 32'(xfer_cyc_log[i+1] - xfer_cyc_log[i]), 1);
        end
        if (xfer_cyc_log.size() > 0)
            checkOutput("halt_latency", 32'(hc - xfer_cyc_log[xfer_cyc_log.size()-1]), 1);
        checkOutput("halt_instr_valid", 32'(instr_valid), 0);
        cnt6 = 0;
        foreach (hs_log[i]) if (hs_log[i] == 14'h0006) cnt6++;
        checkOutput("drain_addr6_once", 32'(cnt6), 1);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req) req_seen++;
        end
        checkOutput("halt_no_req", 32'(req_seen), 0);
        checkOutput("halt_sticky", 32'(halted), 1);
`ifdef IFETCH_PERF_EN
        checkOutput("perf_retired", retired_cnt, 8);
        checkOutput("perf_redirect", 32'(redirect_cnt), 1);
`endif

        // Run 2: stall at pc=2, then wrap from 0x3FFF to 0x0000 into a HALT.
        hs_log.delete();
        xfer_cyc_log.delete();
        mem[0]       = 18'h00101;
        mem[1]       = 18'h00202;
        mem[2]       = 18'h00303;
        mem[3]       = 18'h00404;
        mem[4]       = 18'h2FFFF;
        mem[5]       = 18'h02BBB;
        mem[14'h3FFF] = 18'h00505;
        push_exp(14'h0000, 18'h00101);
        push_exp(14'h0001, 18'h00202);
        applyStimulus(1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("run2_first_present", 32'(instr_valid), 1);
        applyStimulus(1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0);
        hs_before = hs_log.size();
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_pc", 32'(pc), 2);
            checkOutput("hold_instr", 32'(Instruction), 32'h00303);
            tick();
        end
        checkOutput("hold_prefetch_cnt", 32'(hs_log.size() - hs_before), 1);
        if (hs_log.size() > 0)
            checkOutput("hold_prefetch_addr", 32'(hs_log[hs_log.size()-1]), 3);
        checkOutput("hold_req_idle", 32'(imem_req), 0);

        mem[0] = 18'h3C000;
        push_exp(14'h0002, 18'h00303);
        push_exp(14'h0003, 18'h00404);
        push_exp(14'h0004, 18'h2FFFF);
        push_exp(14'h3FFF, 18'h00505);
        push_exp(14'h0000, 18'h3C000);
        applyStimulus(1'b0, 1'b1);
        wait_halted(100, hc);
        checkOutput("run2_all_retired", 32'(exp_q.size()), 0);
        idx = -1;
        foreach (hs_log[i]) if (hs_log[i] == 14'h3FFF) idx = i;
        checkOutput("wrap_next_addr",
                    (idx >= 0 && idx + 1 < hs_log.size()) ? 32'(hs_log[idx+1]) : 32'hFFFF_FFFF, 0);

        // Run 3: reset while a slow request waits, then a stray response right after reset.
        mem[0]   = 18'h00707;
        mem[1]   = 18'h3C000;
        lat_base = 5;
        applyStimulus(1'b1, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        tick();
        checkOutput("wait_req_pending", 32'(imem_req), 1);
        checkOutput("wait_no_valid", 32'(imem_valid), 0);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1);
        force_valid = 1'b1;
        force_data  = 18'h3C000;
        lat_base    = 0;
        checkOutput("post_rst_req_low", 32'(imem_req), 0);
`ifdef IFETCH_PERF_EN
        checkOutput("post_rst_retired", retired_cnt, 0);
        checkOutput("post_rst_redirect", 32'(redirect_cnt), 0);
`endif
        push_exp(14'h0000, 18'h00707);
        push_exp(14'h0001, 18'h3C000);
        tick();
        force_valid = 1'b0;
        wait_halted(50, hc);
        checkOutput("run3_all_retired", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
